spi_atten_scheduler: RTL and testbench
======================================

Name: spi_atten_scheduler

Overview:
- Sequences attenuator write commands from NUM_CH independent channel requesters onto a single shared SPI_Serializer instance on the ZCU111 daughter-board path.
- Latches per-channel requests and grants channels round-robin.
- Formats the 32-bit command word and pulses the serializer load input.
- Detects completion via the serializer chip-select pulse, enforces an inter-frame gap and a completion timeout.

Parameters:
- NUM_CH, 4, number of requesting attenuator channels (2..8).
- ATTEN_W, 6, attenuation code width per channel.
- REG_W, 32, serializer data word width.
- CMD_WRITE, 8'hA5, command byte placed in word bits [23:16].
- LD_CYCLES, 2, clk cycles ser_ld is held high (≥1).
- GAP_CYCLES, 8, idle clk cycles after each frame before the next grant.
- TIMEOUT_CYCLES, 65535, max clk cycles from ser_ld falling edge to ser_cs rising edge.

Ports:
- clk  in  1  system clock, same domain as the serializer.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel single-cycle write request.
- ch_atten  in  NUM_CH*ATTEN_W  channel k code at [k*ATTEN_W +: ATTEN_W], sampled with ch_req[k].
- ch_done  out  NUM_CH  one-cycle pulse when channel k's frame completes.
- err_timeout  out  1  one-cycle pulse on timeout.
- busy  out  1  high in any state other than IDLE.
- ser_data  out  REG_W  word to serializer Data_Register.
- ser_ld  out  1  serializer load strobe.
- ser_cs  in  1  serializer CS output; rising edge marks end of shift.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pending=0, shadow regs=0, rr pointer=0.
  - ser_ld=0, ser_data=0, ch_done=0, err_timeout=0, busy=0.
  - Reset mid-frame drops ser_ld immediately; the in-flight frame is not reported.
- Request latch: at each edge with ch_req[k]=1:
  - pending[k]<=1 and shadow[k]<=ch_atten slice.
  - A repeat request while pending overwrites the shadow; latest value wins and only one frame is sent.
- Word format:
  - ser_data = {8'h00, CMD_WRITE, channel index zero-extended to 8 bits, zero-extended shadow code}.
  - Code occupies bits [ATTEN_W-1:0]; bits [7:ATTEN_W]=0.
  - The serializer shifts LSB first, 24 bits.
- Arbitration:
  - Round-robin search starting at rr pointer; first pending channel wins.
  - On grant, rr <= grant+1, wrapping NUM_CH-1 -> 0.
- States:
  - IDLE: if any pending, then at the next edge: select grant, load ser_data, ser_ld<=1, clear pending[grant], go LOAD. A ch_req for the granted channel on the same edge wins: pending stays 1 with the new shadow.
  - LOAD: hold ser_ld=1 and ser_data for LD_CYCLES cycles, then ser_ld<=0, start timeout counter, go WAIT_CS_H.
  - WAIT_CS_H:
    - On ser_cs rising edge (registered previous value 0, current 1): go WAIT_CS_L.
    - If the counter reaches TIMEOUT_CYCLES first: pulse err_timeout, skip ch_done, go GAP.
  - WAIT_CS_L: on ser_cs=0, pulse ch_done[grant] for 1 cycle, go GAP.
  - GAP: count GAP_CYCLES, then go IDLE.
- Hold and latency rules:
  - ser_data holds its value from LOAD until the next grant.
  - Minimum latency from ch_req to ser_ld high is 2 edges when IDLE.
- Requests arriving in any non-IDLE state are latched and served after GAP.
- ser_cs high while in IDLE is ignored; no ch_done is generated.

Test Plan:
- Single request:
  - Stimulus: ch_req[2] pulse with code 6'd17.
  - Response: ser_data=32'h00A50211; ser_ld high for exactly 2 cycles.
  - After serializer CS pulse: ch_done[2] pulses once, then busy falls after 8 gap cycles.
- Simultaneous requests:
  - Stimulus: ch_req=4'b1111 in one cycle after reset.
  - Response: frames issue in order ch0, ch1, ch2, ch3; each ch_done pulses once.
- Round-robin fairness:
  - Stimulus: ch1 and ch3 re-requested every time they complete.
  - Response: grants alternate 1, 3, 1, 3; ch0 requesting mid-sequence is served at the next wrap.
- Overwrite:
  - Stimulus: ch_req[0] code 5, then code 9 before grant.
  - Response: exactly one frame with code 9.
  - Also: a request on ch0 during its own frame yields a second frame after GAP.
- Timeout:
  - Stimulus: ser_cs tied 0, TIMEOUT_CYCLES=100.
  - Response: err_timeout pulses 100 cycles after ser_ld falls; no ch_done; next pending channel is served.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during WAIT_CS_H.
  - Response: ser_ld=0, busy=0, pending cleared; no ch_done after release.

Source files
------------

// File: rtl/spi_atten_if.sv
// spi_atten_if: channel request/completion and serializer signals of the attenuator scheduler.
interface spi_atten_if #(
  parameter int NUM_CH  = 4,
  parameter int ATTEN_W = 6,
  parameter int REG_W   = 32
);
  logic [NUM_CH-1:0]         ch_req;
  logic [NUM_CH*ATTEN_W-1:0] ch_atten;
  logic [NUM_CH-1:0]         ch_done;
  logic                      err_timeout;
  logic                      busy;
  logic [REG_W-1:0]          ser_data;
  logic                      ser_ld;
  logic                      ser_cs;
  modport master (
    output ch_req, ch_atten, ser_cs,
    input  ch_done, err_timeout, busy, ser_data, ser_ld
  );
  modport slave (
    input  ch_req, ch_atten, ser_cs,
    output ch_done, err_timeout, busy, ser_data, ser_ld
  );
endinterface

// File: rtl/spi_atten_scheduler.sv
// spi_atten_scheduler: round-robin sequencing of per-channel attenuator writes onto one shared SPI serializer.
module spi_atten_scheduler #(
  parameter int         NUM_CH         = 4,
  parameter int         ATTEN_W        = 6,
  parameter int         REG_W          = 32,
  parameter logic [7:0] CMD_WRITE      = 8'hA5,
  parameter int         LD_CYCLES      = 2,
  parameter int         GAP_CYCLES     = 8,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst_n,
  spi_atten_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_CS_H = 3'd2, WAIT_CS_L = 3'd3, GAP = 3'd4;
  logic [2:0] state;
  logic [NUM_CH-1:0] pending, clr, done;
  logic [ATTEN_W-1:0] shadow [NUM_CH];
  logic [IW-1:0] rr, gnt, cur;
  logic [31:0] cnt;
  logic [REG_W-1:0] data;
  logic cs_q, ld, err, found;
  int j;
  // first pending channel at or after the round-robin pointer
  always_comb begin
    gnt = rr;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr) + i;
      j = j >= NUM_CH ? j - NUM_CH : j;
      if (!found && pending[IW'(j)]) begin
        gnt = IW'(j);
        found = 1'b1;
      end
    end
  end
  assign clr = (state == IDLE && found) ? NUM_CH'(1) << gnt : '0;
  assign bus.busy = state != IDLE;
  assign bus.ser_ld = ld;
  assign bus.ser_data = data;
  assign bus.ch_done = done;
  assign bus.err_timeout = err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      rr <= '0;
      cur <= '0;
      cnt <= '0;
      cs_q <= 1'b0;
      ld <= 1'b0;
      data <= '0;
      done <= '0;
      err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else begin
      cs_q <= bus.ser_cs;
      done <= '0;
      err <= 1'b0;
      // a request on the grant edge re-arms the channel with its new code
      pending <= (pending & ~clr) | bus.ch_req;
      for (int k = 0; k < NUM_CH; k++)
        if (bus.ch_req[k]) shadow[k] <= bus.ch_atten[k*ATTEN_W +: ATTEN_W];
      case (state)
        IDLE:
          if (found) begin
            cur <= gnt;
            rr <= gnt == IW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
            data <= REG_W'({8'h00, CMD_WRITE, 8'(gnt), 8'(shadow[gnt])});
            ld <= 1'b1;
            cnt <= '0;
            state <= LOAD;
          end
        LOAD:
          if (cnt == 32'(LD_CYCLES - 1)) begin
            ld <= 1'b0;
            cnt <= '0;
            state <= WAIT_CS_H;
          end else cnt <= cnt + 1'b1;
        WAIT_CS_H:
          if (!cs_q && bus.ser_cs) state <= WAIT_CS_L;
          else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            err <= 1'b1;
            cnt <= '0;
            state <= GAP;
          end else cnt <= cnt + 1'b1;
        WAIT_CS_L:
          if (!bus.ser_cs) begin
            done <= NUM_CH'(1) << cur;
            cnt <= '0;
            state <= GAP;
          end
        GAP:
          if (cnt == 32'(GAP_CYCLES - 1)) state <= IDLE;
          else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_atten_scheduler.sv
// tb_spi_atten_scheduler: directed stimulus with a frame/completion scoreboard and a simple serializer model.
module tb_spi_atten_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, mute = 1'b0, sld_q = 1'b0, ld_q = 1'b0;
  int checks = 0, errors = 0, ld_len = 0;
  logic [31:0] exp_word[$];
  logic [7:0] exp_evt[$];
  logic [7:0] ev;

  spi_atten_if #(.NUM_CH(4), .ATTEN_W(6), .REG_W(32)) bus();
  spi_atten_scheduler #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] w(int ch, int code);
    return {8'h00, 8'hA5, 8'(ch), 8'(code)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic req(logic [3:0] m, int c0, int c1, int c2, int c3);
    bus.ch_req = m;
    bus.ch_atten = {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
    @(negedge clk);
    bus.ch_req = '0;
  endtask

  // sel: 0 ser_ld high, 1 ser_ld low, 2 err_timeout, 3 ch_done & m
  task automatic wait_ev(string name, int sel, logic [3:0] m);
    int n = 0;
    bit hit = 1'b0;
    do begin
      @(negedge clk);
      n++;
      hit = sel == 0 ? bus.ser_ld : sel == 1 ? !bus.ser_ld : sel == 2 ? bus.err_timeout : |(bus.ch_done & m);
    end while (!hit && n < 1000);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: not seen within %0d cycles", name, n);
    end
  endtask

  task automatic wait_quiet();
    int n = 0, q = 0;
    while (q < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      q = bus.busy ? 0 : q + 1;
    end
    checks++;
    if (q < 12) begin
      errors++;
      $display("FAIL quiet: busy still high after %0d cycles", n);
    end
  endtask

  // serializer model: CS pulse some time after each load strobe, unless muted
  initial begin
    bus.ser_cs = 1'b0;
    forever begin
      @(negedge clk);
      if (sld_q && !bus.ser_ld && !mute) begin
        repeat (24) @(negedge clk);
        bus.ser_cs = 1'b1;
        repeat (3) @(negedge clk);
        bus.ser_cs = 1'b0;
      end
      sld_q = bus.ser_ld;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ser_ld && !ld_q) begin
        if (exp_word.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: unexpected word %h", bus.ser_data);
        end else chk("frame word", bus.ser_data, exp_word.pop_front());
      end
      if (!bus.ser_ld && ld_q) chk("ld width", ld_len, 2);
      ld_len = bus.ser_ld ? ld_len + 1 : 0;
      if (bus.ch_done != 0 || bus.err_timeout) begin
        ev = {bus.err_timeout, 3'b000, bus.ch_done};
        if (exp_evt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL completion: unexpected event %h", ev);
        end else chk("completion", ev, exp_evt.pop_front());
      end
    end else ld_len = 0;
    ld_q = bus.ser_ld;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ch_req = '0;
    bus.ch_atten = '0;
    repeat (3) @(negedge clk);
    chk("reset ser_ld", bus.ser_ld, 0);
    chk("reset ser_data", bus.ser_data, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset ch_done", bus.ch_done, 0);
    chk("reset err_timeout", bus.err_timeout, 0);
    rst_n = 1'b1;

    // single request on ch2
    exp_word.push_back(32'h00A50211);
    exp_evt.push_back(8'h04);
    req(4'b0100, 0, 0, 17, 0);
    chk("latency edge1 ld", bus.ser_ld, 0);
    @(negedge clk);
    chk("latency edge2 ld", bus.ser_ld, 1);
    wait_ev("ch2 done", 3, 4'b0100);
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gap cycles", n, 8);
    chk("data hold", bus.ser_data, 32'h00A50211);

    // simultaneous requests right after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_word.push_back(w(c, c + 1));
      exp_evt.push_back(8'(1 << c));
    end
    req(4'b1111, 1, 2, 3, 4);
    wait_quiet();

    // round-robin fairness with re-requests, ch0 joins mid-sequence
    exp_word.push_back(w(1, 10)); exp_evt.push_back(8'h02);
    exp_word.push_back(w(3, 20)); exp_evt.push_back(8'h08);
    exp_word.push_back(w(1, 11)); exp_evt.push_back(8'h02);
    exp_word.push_back(w(3, 21)); exp_evt.push_back(8'h08);
    exp_word.push_back(w(0, 33)); exp_evt.push_back(8'h01);
    exp_word.push_back(w(1, 12)); exp_evt.push_back(8'h02);
    req(4'b1010, 0, 10, 0, 20);
    wait_ev("rr ch1 done a", 3, 4'b0010);
    req(4'b0010, 0, 11, 0, 0);
    wait_ev("rr ch3 done a", 3, 4'b1000);
    req(4'b1000, 0, 0, 0, 21);
    wait_ev("rr ch1 done b", 3, 4'b0010);
    req(4'b0011, 33, 12, 0, 0);
    wait_quiet();

    // overwrite while pending, then re-request during own frame
    exp_word.push_back(w(2, 7));  exp_evt.push_back(8'h04);
    exp_word.push_back(w(0, 9));  exp_evt.push_back(8'h01);
    exp_word.push_back(w(0, 13)); exp_evt.push_back(8'h01);
    req(4'b0100, 0, 0, 7, 0);
    repeat (2) @(negedge clk);
    req(4'b0001, 5, 0, 0, 0);
    req(4'b0001, 9, 0, 0, 0);
    wait_ev("ovr ch2 done", 3, 4'b0100);
    wait_ev("ovr ch0 load", 0, 4'b0000);
    req(4'b0001, 13, 0, 0, 0);
    wait_quiet();

    // timeout on ch1, ch2 then served normally
    mute = 1'b1;
    exp_word.push_back(w(1, 3)); exp_evt.push_back(8'h80);
    exp_word.push_back(w(2, 4)); exp_evt.push_back(8'h04);
    req(4'b0110, 0, 3, 4, 0);
    wait_ev("to load high", 0, 4'b0000);
    wait_ev("to load low", 1, 4'b0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.err_timeout && n < 300);
    chk("timeout cycles", n, 100);
    mute = 1'b0;
    wait_quiet();

    // reset during WAIT_CS_H with ch0 pending
    mute = 1'b1;
    exp_word.push_back(w(3, 5));
    req(4'b1000, 0, 0, 0, 5);
    wait_ev("rst load high", 0, 4'b0000);
    wait_ev("rst load low", 1, 4'b0000);
    repeat (5) @(negedge clk);
    req(4'b0001, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ser_ld", bus.ser_ld, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst ser_data", bus.ser_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
    repeat (200) @(negedge clk);
    chk("post reset busy", bus.busy, 0);
    chk("words left", exp_word.size(), 0);
    chk("events left", exp_evt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
